// File: rtl/piso_serializer.sv
// LSB-first parallel-in/serial-out serializer with a valid/ready load handshake.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             serial_valid_q;
  logic             done_q;
  logic             load_ready_q;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  // Zero-filled shifting leaves the register empty once a frame has fully drained.
  assign shift_d = {1'b0, shift_q[WIDTH-1:1]};
  assign cnt_d   = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      serial_valid_q <= 1'b0;
      done_q         <= 1'b0;
      load_ready_q   <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid && load_ready_q) begin
            state_q        <= SHIFT;
            shift_q        <= load_data;
            cnt_q          <= '0;
            serial_valid_q <= 1'b1;
            done_q         <= 1'b0;
            load_ready_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q       <= ^load_data;
`endif
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
            state_q        <= PARITY;
            serial_valid_q <= 1'b1;
            done_q         <= 1'b1;
            load_ready_q   <= 1'b0;
`else
            state_q        <= IDLE;
            serial_valid_q <= 1'b0;
            done_q         <= 1'b0;
            load_ready_q   <= 1'b1;
`endif
          end else begin
            cnt_q          <= cnt_d;
            serial_valid_q <= 1'b1;
            load_ready_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            done_q         <= 1'b0;
`else
            done_q         <= (cnt_d == LAST);
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state_q        <= IDLE;
          serial_valid_q <= 1'b0;
          done_q         <= 1'b0;
          load_ready_q   <= 1'b1;
        end
`endif
        default: begin
          state_q        <= IDLE;
          serial_valid_q <= 1'b0;
          done_q         <= 1'b0;
          load_ready_q   <= 1'b1;
        end
      endcase
    end
  end

`ifdef PISO_PARITY_EN
  assign serial_out = (state_q == PARITY) ? parity_q : shift_q[0];
`else
  assign serial_out = shift_q[0];
`endif
  assign serial_valid = serial_valid_q;
  assign done         = done_q;
  assign load_ready   = load_ready_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=8), with or without PISO_PARITY_EN.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       serial_out;
  logic       serial_valid;
  logic       done;

  int passCount = 0;
  int failCount = 0;
  int total     = 0;

  piso_serializer #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, " idle valid"}, 32'(serial_valid), 32'd0);
    checkVal({tag, " idle out"},   32'(serial_out),   32'd0);
    checkVal({tag, " idle ready"}, 32'(load_ready),   32'd1);
    checkVal({tag, " idle done"},  32'(done),         32'd0);
  endtask

  // Called in the first cycle after the handshake edge; returns in the following idle cycle.
  task automatic expectFrame(input logic [7:0] w, input bit disturb, input string tag);
    logic expDone;
    for (int i = 0; i < 8; i++) begin
`ifdef PISO_PARITY_EN
      expDone = 1'b0;
`else
      expDone = (i == 7);
`endif
      checkVal($sformatf("%s bit%0d out", tag, i),   32'(serial_out),   32'(w[i]));
      checkVal($sformatf("%s bit%0d valid", tag, i), 32'(serial_valid), 32'd1);
      checkVal($sformatf("%s bit%0d ready", tag, i), 32'(load_ready),   32'd0);
      checkVal($sformatf("%s bit%0d done", tag, i),  32'(done),         32'(expDone));
      if (disturb) begin
        load_valid = i[0];
        load_data  = 8'hFF ^ 8'(i * 37);
      end
      tick();
    end
`ifdef PISO_PARITY_EN
    checkVal({tag, " parity out"},   32'(serial_out),   32'(^w));
    checkVal({tag, " parity valid"}, 32'(serial_valid), 32'd1);
    checkVal({tag, " parity done"},  32'(done),         32'd1);
    checkVal({tag, " parity ready"}, 32'(load_ready),   32'd0);
    tick();
`endif
    checkIdle(tag);
  endtask

  task automatic loadWord(input logic [7:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    // Reset held two cycles while a word is offered: nothing may be captured.
    reset      = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    tick();
    checkIdle("reset1");
    tick();
    checkIdle("reset2");
    reset      = 1'b1;
    load_valid = 1'b0;
    tick();
    checkIdle("post-reset");

    // Single frame.
    loadWord(8'b1011_0010);
    expectFrame(8'b1011_0010, 1'b0, "B2");

    // Back-to-back with load_valid held high; the second word is offered during the first frame.
    load_valid = 1'b1;
    load_data  = 8'hA5;
    tick();
    load_data  = 8'h3C;
    expectFrame(8'hA5, 1'b0, "A5");
    tick();
    load_valid = 1'b0;
    expectFrame(8'h3C, 1'b0, "3C");

    // Mid-frame reset at bit 3 aborts the frame with no done pulse.
    loadWord(8'hF0);
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("F0 bit%0d out", i), 32'(serial_out), 32'd0);
      tick();
    end
    checkVal("F0 bit3 valid", 32'(serial_valid), 32'd1);
    reset = 1'b0;
    tick();
    checkIdle("abort");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal($sformatf("abort quiet%0d done", i),  32'(done),         32'd0);
      checkVal($sformatf("abort quiet%0d valid", i), 32'(serial_valid), 32'd0);
    end
    loadWord(8'h01);
    expectFrame(8'h01, 1'b0, "01");

    // Reset wins over a simultaneous handshake.
    reset      = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'h55;
    tick();
    reset      = 1'b1;
    load_valid = 1'b0;
    checkIdle("rst-prio");
    tick();
    checkIdle("rst-prio2");

    // Inputs toggled during SHIFT must not disturb the captured stream.
    loadWord(8'h6E);
    expectFrame(8'h6E, 1'b1, "6E");
    load_valid = 1'b0;

    // Parity-distinguishing words: odd and even number of ones.
    loadWord(8'h07);
    expectFrame(8'h07, 1'b0, "07");
    loadWord(8'h03);
    expectFrame(8'h03, 1'b0, "03");

    $display("%0d/%0d checks passed", passCount, total);
    $finish;
  end

endmodule
